// File: rtl/uart_bus_responder_if.sv
// Native picosoc memory bus between a CPU-side master and the UART responder.
// Handshake: the master raises mem_valid with addr/wdata/wstrb and holds them stable until
// mem_ready; mem_ready is a one-cycle pulse that completes the transfer, and mem_valid seen
// in the cycle right after that pulse is ignored so a late deassertion cannot start a repeat.
interface uart_bus_responder_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART: divider and data registers on the picosoc native bus,
// an 8N1 transmitter and a receiver feeding a small receive FIFO.
module uart_bus_responder #(
    parameter logic [31:0] DIV_ADDR    = 32'h0200_0004,
    parameter logic [31:0] DATA_ADDR   = 32'h0200_0008,
    parameter logic [31:0] DEFAULT_DIV = 32'd138,
    parameter int          RX_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_bus_responder_if.slave  bus,
    output logic                 ser_tx,
    input  logic                 ser_rx,
    output logic [1:0]           tx_state_dbg,
    output logic [1:0]           rx_state_dbg
);
    localparam int PW = $clog2(RX_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(RX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [31:0] div_q;
    logic [31:0] eff_div;
    logic        ignore_q;
    logic        tx_go;
    logic [7:0]  tx_byte;

    logic        hit_div, hit_data, req_ok, is_wr, tx_free;
    logic        acc_div, acc_rd, acc_dw, pop, push_ok, empty, full;

    tx_state_t   tx_state, tx_state_n;
    logic [31:0] tx_cnt, tx_cnt_n, tx_per, tx_per_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_line_n;

    rx_state_t   rx_state, rx_state_n;
    logic [31:0] rx_cnt, rx_cnt_n, rx_per, rx_per_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_push;
    logic        rx_s1, rx_s2, rx_s3;

    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    // Very small dividers cannot fit the RX half-bit and centre sampling.
    assign eff_div = (div_q < 32'd3) ? 32'd3 : div_q;

    assign hit_div  = (bus.mem_addr == DIV_ADDR);
    assign hit_data = (bus.mem_addr == DATA_ADDR);
    assign req_ok   = bus.mem_valid && !bus.mem_ready && !ignore_q;
    assign is_wr    = |bus.mem_wstrb;
    assign tx_free  = (tx_state == TX_IDLE) && !tx_go;
    assign acc_div  = req_ok && hit_div;
    assign acc_rd   = req_ok && hit_data && !is_wr;
    assign acc_dw   = req_ok && hit_data && is_wr && (!bus.mem_wstrb[0] || tx_free);

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = acc_rd && !empty;
    assign push_ok = rx_push && (!full || pop);

    assign tx_state_dbg = tx_state;
    assign rx_state_dbg = rx_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= 32'd0;
            ignore_q      <= 1'b0;
            div_q         <= DEFAULT_DIV;
            tx_go         <= 1'b0;
            tx_byte       <= 8'd0;
        end else begin
            bus.mem_ready <= acc_div || acc_rd || acc_dw;
            ignore_q      <= bus.mem_ready;
            tx_go         <= acc_dw && bus.mem_wstrb[0];
            if (acc_dw && bus.mem_wstrb[0])
                tx_byte <= bus.mem_wdata[7:0];
            if (acc_div) begin
                if (is_wr) begin
                    for (int i = 0; i < 4; i++)
                        if (bus.mem_wstrb[i])
                            div_q[8*i +: 8] <= bus.mem_wdata[8*i +: 8];
                end else begin
                    bus.mem_rdata <= div_q;
                end
            end
            if (acc_rd)
                bus.mem_rdata <= empty ? 32'hFFFF_FFFF : {24'd0, fifo_mem[rd_ptr]};
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_per_n   = tx_per;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = 1'b1;
        case (tx_state)
            TX_IDLE: if (tx_go) begin
                tx_state_n = TX_START;
                tx_cnt_n   = 32'd0;
                tx_per_n   = eff_div;
                tx_shift_n = tx_byte;
            end
            TX_START: if (tx_cnt >= tx_per) begin
                tx_state_n = TX_DATA;
                tx_cnt_n   = 32'd0;
                tx_per_n   = eff_div;
                tx_bit_n   = 3'd0;
            end else tx_cnt_n = tx_cnt + 32'd1;
            TX_DATA: if (tx_cnt >= tx_per) begin
                tx_cnt_n   = 32'd0;
                tx_per_n   = eff_div;
                tx_shift_n = {1'b0, tx_shift[7:1]};
                if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                else tx_bit_n = tx_bit + 3'd1;
            end else tx_cnt_n = tx_cnt + 32'd1;
            TX_STOP: if (tx_cnt >= tx_per) tx_state_n = TX_IDLE;
                     else tx_cnt_n = tx_cnt + 32'd1;
            default: tx_state_n = TX_IDLE;
        endcase
        // The line is registered from the next state so it changes on the bit boundary edge.
        case (tx_state_n)
            TX_START: tx_line_n = 1'b0;
            TX_DATA:  tx_line_n = tx_shift_n[0];
            default:  tx_line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 32'd0;
            tx_per   <= 32'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            ser_tx   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_per   <= tx_per_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            ser_tx   <= tx_line_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_per_n   = rx_per;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        case (rx_state)
            RX_IDLE: if (rx_s3 && !rx_s2) begin
                rx_state_n = RX_START;
                rx_cnt_n   = 32'd0;
                rx_per_n   = eff_div;
            end
            RX_START: if (rx_cnt >= (rx_per >> 1)) begin
                rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                rx_cnt_n   = 32'd0;
                rx_per_n   = eff_div;
                rx_bit_n   = 3'd0;
            end else rx_cnt_n = rx_cnt + 32'd1;
            RX_DATA: if (rx_cnt >= rx_per) begin
                rx_cnt_n   = 32'd0;
                rx_per_n   = eff_div;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                else rx_bit_n = rx_bit + 3'd1;
            end else rx_cnt_n = rx_cnt + 32'd1;
            RX_STOP: if (rx_cnt >= rx_per) begin
                rx_push    = rx_s2;
                rx_state_n = RX_IDLE;
            end else rx_cnt_n = rx_cnt + 32'd1;
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 32'd0;
            rx_per   <= 32'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            rx_s1    <= ser_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_per   <= rx_per_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      count <= count + (PW+1)'(1);
            else if (!push_ok && pop) count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= rx_shift;
    end
endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder: register access, TX framing and stall,
// RX FIFO ordering/overflow/glitch/framing error, reset abort and bus guard behaviour.
module tb_uart_bus_responder;
    localparam logic [31:0] DIV_ADDR  = 32'h0200_0004;
    localparam logic [31:0] DATA_ADDR = 32'h0200_0008;
    localparam int          DEPTH     = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ser_rx = 1'b1;
    logic       ser_tx;
    logic [1:0] tx_state_dbg, rx_state_dbg;

    uart_bus_responder_if bus();

    uart_bus_responder #(.RX_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .ser_tx(ser_tx), .ser_rx(ser_rx),
        .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [0:0]  tx_exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wstrb = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        int w = 0;
        bit got = 1'b0;
        tick(2);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = 4'd0;
        while (!got && w < 20) begin
            tick(1);
            w++;
            got = bus.mem_ready;
        end
        bus_idle();
        check({tag, "_ready"}, 32'(got), 32'd1);
        if (got) begin
            check(tag, bus.mem_rdata, exp);
            check({tag, "_lat"}, 32'(w), 32'd1);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int limit, output int waited);
        int w = 0;
        bit got = 1'b0;
        tick(2);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        bus.mem_wstrb = strb;
        while (!got && w < limit) begin
            tick(1);
            w++;
            got = bus.mem_ready;
        end
        bus_idle();
        waited = got ? w : -1;
    endtask

    // FIFO model: bytes with a good stop bit enter unless the model is already full.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok);
        ser_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            ser_rx = data[i];
            tick(10);
        end
        ser_rx = stop_ok;
        tick(10);
        ser_rx = 1'b1;
        tick(4);
        if (stop_ok && exp_q.size() < DEPTH) exp_q.push_back({24'd0, data});
    endtask

    task automatic read_data(input string tag);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        bus_read(DATA_ADDR, e, tag);
    endtask

    task automatic read_data_hold(input string tag);
        logic [31:0] e;
        int w = 0;
        int extra = 0;
        bit got = 1'b0;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        tick(2);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = DATA_ADDR;
        bus.mem_wstrb = 4'd0;
        while (!got && w < 20) begin
            tick(1);
            w++;
            got = bus.mem_ready;
        end
        repeat (2) begin
            tick(1);
            if (bus.mem_ready) extra++;
        end
        bus_idle();
        check({tag, "_ready"}, 32'(got), 32'd1);
        check(tag, bus.mem_rdata, e);
        check({tag, "_extra"}, 32'(extra), 32'd0);
    endtask

    task automatic push_tx_frame(input logic [7:0] data);
        tx_exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_exp_q.push_back(data[i]);
        tx_exp_q.push_back(1'b1);
    endtask

    // Called right after the accepting pulse is seen; samples each bit at its centre.
    task automatic tx_capture(input string tag);
        logic [0:0] e;
        tick(6);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick(10);
            e = tx_exp_q.pop_front();
            check($sformatf("%s_bit%0d", tag, k), 32'(ser_tx), 32'(e));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, rdy;
        logic [7:0] b;
        bus_idle();
        tick(3);
        check("rst_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_ser_tx", 32'(ser_tx), 32'd1);
        check("rst_tx_state", 32'(tx_state_dbg), 32'd0);
        check("rst_rx_state", 32'(rx_state_dbg), 32'd0);
        reset = 1'b0;

        bus_read(DIV_ADDR, 32'h0000_008A, "div_reset");
        read_data("data_empty");
        check("idle_ser_tx", 32'(ser_tx), 32'd1);

        bus_write(DIV_ADDR, 32'h0000_0009, 4'b0001, 20, w);
        check("div_wr_lat", 32'(w), 32'd1);
        bus_read(DIV_ADDR, 32'h0000_0009, "div_9");
        bus_write(DIV_ADDR, 32'hAABB_CCDD, 4'b1010, 20, w);
        bus_read(DIV_ADDR, 32'hAA00_CC09, "div_lanes");
        bus_write(DIV_ADDR, 32'h0000_0009, 4'b1111, 20, w);
        bus_read(DIV_ADDR, 32'h0000_0009, "div_restore");

        // Frame 0x41, with a second write landing mid-frame that must wait for STOP.
        push_tx_frame(8'h41);
        bus_write(DATA_ADDR, 32'h0000_0041, 4'b0001, 20, w);
        check("tx_wr_lat", 32'(w), 32'd1);
        fork
            tx_capture("tx41");
            begin
                tick(30);
                bus_write(DATA_ADDR, 32'h0000_0042, 4'b0001, 200, w2);
                check("tx_stall_wait", 32'(w2), 32'd70);
            end
        join
        tick(35);
        check("tx42_bit2", 32'(ser_tx), 32'd0);
        reset = 1'b1;
        tick(1);
        check("rst_mid_ser_tx", 32'(ser_tx), 32'd1);
        check("rst_mid_tx_state", 32'(tx_state_dbg), 32'd0);
        tick(2);
        reset = 1'b0;
        bus_read(DIV_ADDR, 32'h0000_008A, "div_after_rst");
        bus_write(DIV_ADDR, 32'h0000_0009, 4'b0001, 20, w);

        bus_write(DATA_ADDR, 32'h0000_0055, 4'b0010, 20, w);
        check("dw_nolane_lat", 32'(w), 32'd1);
        tick(3);
        check("dw_nolane_ser_tx", 32'(ser_tx), 32'd1);
        check("dw_nolane_state", 32'(tx_state_dbg), 32'd0);

        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        read_data("rx_55");
        read_data("rx_a3");
        read_data("rx_empty");

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
        end
        for (int i = 0; i < 5; i++) read_data($sformatf("rx_ovf%0d", i));

        ser_rx = 1'b0;
        tick(1);
        ser_rx = 1'b1;
        tick(30);
        read_data("rx_glitch");

        send_frame(8'h3C, 1'b0);
        read_data("rx_framing");
        send_frame(8'h5A, 1'b1);
        read_data("rx_recover");

        send_frame(8'($urandom_range(0, 255)), 1'b1);
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        read_data_hold("rx_hold");
        read_data("rx_hold_next");
        read_data("rx_hold_empty");

        tick(2);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0200_000C;
        bus.mem_wstrb = 4'd0;
        rdy = 0;
        repeat (20) begin
            tick(1);
            if (bus.mem_ready) rdy++;
        end
        bus_idle();
        check("unmapped_ready", 32'(rdy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_bus_responder.md
# uart_bus_responder

Memory-mapped UART peripheral that answers the picosoc native memory bus (`mem_valid`/`mem_ready`) at the serial divider and serial data addresses. It is the responder for the firmware loader and for CPU firmware: it configures the baud divider, serialises written bytes onto `ser_tx`, and deserialises `ser_rx` into a small receive FIFO. A read of the data register returns all-ones when no byte is available.

## Interface
- `DIV_ADDR`, default 32'h0200_0004: word address of the divider register.
- `DATA_ADDR`, default 32'h0200_0008: word address of the data register.
- `DEFAULT_DIV`, default 32'd138: divider value loaded at reset. Bit period is `div+1` clocks.
- `RX_DEPTH`, default 4: receive FIFO entries. Must be a power of two, 2..16.
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `mem_valid`, input, 1: request from the bus master.
- `mem_ready`, output, 1: single-cycle completion pulse.
- `mem_addr`, input, 32: request address. Only exact matches on `DIV_ADDR` or `DATA_ADDR` are answered.
- `mem_wdata`, input, 32: write data.
- `mem_wstrb`, input, 4: byte strobes. All zero means a read.
- `mem_rdata`, output, 32: read data. Valid in the cycle `mem_ready` is high.
- `ser_tx`, output, 1: UART transmit line. Idles high.
- `ser_rx`, input, 1: UART receive line. Asynchronous.

## Operation
- Reset values: `mem_ready`=0, `mem_rdata`=0, `ser_tx`=1, `div`=`DEFAULT_DIV`. The FIFO is empty, and the TX and RX state machines are IDLE.
- Reset asserted mid-frame aborts both frames. A partial RX byte is discarded and `ser_tx` returns high on the next edge.
- Address decode:
  - A request whose address matches neither register is never acknowledged; `mem_ready` stays 0.
  - Other slaves own those requests.
- Divider write (`DIV_ADDR`, wstrb≠0):
  - Each byte lane with its strobe set updates the matching byte of `div`.
  - Effective divider is `max(div,3)`.
  - A new value takes effect at the next bit boundary of any frame in progress.
- Divider read: returns `div`.
- Data write (`DATA_ADDR`, `wstrb[0]`=1):
  - If TX is busy, hold `mem_ready` low until TX is IDLE.
  - Then latch `mem_wdata[7:0]`, pulse `mem_ready`, and start the frame.
- Data write with `wstrb[0]`=0 and wstrb≠0: acknowledged, no effect.
- Data read (`DATA_ADDR`, wstrb=0):
  - FIFO non-empty: return {24'b0, head byte} and pop.
  - FIFO empty: return 32'hFFFF_FFFF with no pop.
  - Never stalls.
- TX FSM: IDLE → START (`ser_tx`=0, one bit period) → DATA (8 bits, LSB first) → STOP (`ser_tx`=1, one bit period) → IDLE.
- RX FSM:
  - `ser_rx` passes through a 2-flop synchroniser.
  - IDLE → START on a synchronised falling edge.
  - START: at half a bit period (`div/2`, truncated), go to DATA if the line is still low, else back to IDLE (glitch).
  - DATA: sample 8 bits at bit centres, spaced `div+1` clocks apart, LSB first.
  - STOP: sample at the stop bit centre. If high, push the byte; if low, discard it (framing error). Then return to IDLE.
  - A push into a full FIFO drops the new byte; the FIFO contents are unchanged.
- Pop and push in the same cycle are both honoured, and the occupancy count stays the same. Pointers wrap modulo `RX_DEPTH`.

## Timing
- Requests are evaluated on the registered edge. `mem_ready` rises the cycle after `mem_valid` is first seen with a decoded address, or the cycle after TX becomes IDLE for a stalled write.
- `mem_ready` is high for exactly one cycle.
- The cycle after a `mem_ready` pulse, `mem_valid` is ignored. This covers the master deasserting valid one cycle late, and no second transaction is started.
- Read latency is 1 cycle. Write latency is 1 cycle when TX is idle.
- The first `ser_tx` low occurs on the cycle after the `mem_ready` that accepts the byte. A frame lasts 10×(`div`+1) clocks.
- RX byte visibility: a byte can be read 1 cycle after the stop-bit sample.
- `mem_rdata` holds its last value between transactions.

## Test plan
- After reset, read `DIV_ADDR` → 32'h0000_008A on the pulse. Read `DATA_ADDR` → 32'hFFFF_FFFF. `ser_tx`=1.
- Write 32'h0000_0009 to `DIV_ADDR`, wstrb=4'b0001, then write 8'h41 to data → `ser_tx` carries 0,1,0,0,0,0,0,1,0,1 with 10 clocks per bit. A second write issued mid-frame stalls until STOP ends.
- With div=9, drive RX frames 8'h55, 8'hA3 → two reads return 32'h55 then 32'hA3, and a third read returns 32'hFFFF_FFFF.
- Drive 6 RX bytes with `RX_DEPTH`=4 and no reads → reads return the first 4 bytes in order, then all-ones. Also drive a 1-clock low glitch on `ser_rx` → nothing pushed.
- Drive an RX frame with stop bit 0 → byte discarded. Apply `reset` mid-TX frame → `ser_tx`=1 next cycle and `div`=138.
- Hold `mem_valid` at `DATA_ADDR` for 2 cycles past the pulse → exactly one pop. Request at 32'h0200_000C → `mem_ready` never asserts.
